change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Pays out change owed by the vending FSM. Sits between fsm_controller (change_returning/change_due) and the coin hopper.
//  Latches each change request, decomposes it greedily into three coin denominations and ejects one coin per 4-phase handshake.
//  Tracks per-tube inventory and flags when the amount owed cannot be paid.
// PARAMETERS
//  DENOM_A         5     largest coin value (credit units), tube sel 2'd0
//  DENOM_B         2     middle coin value, tube sel 2'd1
//  DENOM_C         1     smallest coin value, tube sel 2'd2
//  INV_INIT        8     coins per tube after reset/refill (4-bit, max 15)
//  TIMEOUT_CYCLES  1000  ack watchdog limit (used only with CHANGE_TIMEOUT_EN)
// PORTS
//  clk              in   1  clock
//  rst              in   1  reset, asynchronous, active-high
//  change_returning in   1  1-cycle pulse: change_due is valid
//  change_due       in   8  amount owed, credit units
//  refill           in   1  pulse: set all tubes to INV_INIT (honoured only in IDLE)
//  eject_req        out  1  hopper request; held high until eject_ack high
//  eject_sel        out  2  tube select, stable while eject_req high
//  eject_ack        in   1  hopper ack (4-phase)
//  busy             out  1  high in every state except IDLE
//  remaining        out  8  amount still owed
//  inv_a/inv_b/inv_c out 4  coins left per tube
//  dispense_done    out  1  1-cycle pulse: remaining reached 0
//  short_flag       out  1  1-cycle pulse: payout stopped with remaining != 0
//  timeout_flag     out  1  1-cycle pulse: hopper ack watchdog expired
// BEHAVIOUR
//  Reset: eject_req=0, eject_sel=0, busy=0, remaining=0, flags=0, inv_*=INV_INIT, state IDLE. Mid-payout reset drops eject_req at once; the debt is lost.
//  States: IDLE, SELECT, EJECT, RELEASE, DONE, SHORT.
//  IDLE: change_returning -> remaining += change_due (saturate 255), go SELECT. If change_due=0, go SELECT anyway and end via DONE.
//  SELECT: remaining==0 -> DONE. Else choose the largest denom d with d<=remaining and inv_d>0, set eject_sel, go EJECT. No such d -> SHORT.
//  EJECT: eject_req=1. On eject_ack=1: remaining -= d, inv_d -= 1, eject_req=0, go RELEASE.
//  RELEASE: wait eject_ack=0, then go SELECT. Never re-assert req while ack is high.
//  DONE: dispense_done pulse, go IDLE. SHORT: short_flag pulse, go IDLE; remaining keeps the unpaid amount.
//  Latency: change_returning at cycle N -> eject_req high at N+2.
//  change_returning while busy: its amount is added to remaining (saturate 255), never dropped.
//   - Coincides with the ack decrement: remaining <= remaining - d + change_due (saturating).
//  IDLE with remaining!=0 after SHORT: the next change_returning adds to it; refill alone does not restart payout.
//  refill outside IDLE: ignored. refill with change_returning in IDLE: both take effect.
//  The eject_ack input is ignored in IDLE, SELECT, DONE and SHORT.
//  Arithmetic: 9-bit sum, clamped to 8'hFF; inventory never decrements below 0 because SELECT excludes empty tubes.
// CONFIGURATION
//  `define CHANGE_TIMEOUT_EN: 10-bit counter runs in EJECT and RELEASE and clears on each state change.
//   - At TIMEOUT_CYCLES: eject_req=0, timeout_flag pulse, go SHORT; no inventory or remaining change for that coin.
//  Without the macro: the block waits indefinitely for ack; timeout_flag is tied to 0; no counter logic is built.
// STRUCTURE
//  Shared package (vend_defs.vh): denomination defaults, tube select codes, state encodings, credit width (8).
//   - Shared with fsm_controller so both agree on credit units.
//  Sub-module coin_selector (combinational): remaining + inv_* -> found, sel, denom.
//  The FSM, remaining register, inventory counters and watchdog live in change_dispenser.
// TESTING
//  Reset, then change_due=8 -> tubes A,B,C ejected (5,2,1); dispense_done; remaining=0; inv_a=7, inv_b=7, inv_c=7.
//  change_due=4 -> two B ejects; remaining 4->2->0; eject_req first high 2 cycles after the pulse.
//  INV_INIT=2, change_due=20 -> A,A,B,B,C,C; short_flag pulse; remaining=4.
//  change_due=5 with a second change_returning=3 during the first EJECT -> total paid 8; one dispense_done.
//  Assert rst while eject_req high -> eject_req low the same cycle; remaining=0; inv_*=INV_INIT.
//  CHANGE_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack held low -> timeout_flag, then short_flag; remaining unchanged.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: credit width, tube select codes,
// denomination defaults, FSM state encoding and saturating credit arithmetic.
package change_dispenser_pkg;

   localparam int unsigned CreditW = 8;

   localparam int unsigned DenomADefault = 5;
   localparam int unsigned DenomBDefault = 2;
   localparam int unsigned DenomCDefault = 1;

   localparam logic [1:0] SelA = 2'd0;
   localparam logic [1:0] SelB = 2'd1;
   localparam logic [1:0] SelC = 2'd2;

   typedef enum logic [2:0] {
      StIdle,
      StSelect,
      StEject,
      StRelease,
      StDone,
      StShort
   } state_e;

   // Sum of two credit values, clamped to the largest representable amount.
   function automatic logic [CreditW-1:0] sat_add(input logic [CreditW-1:0] a,
                                                  input logic [CreditW-1:0] b);
      logic [CreditW:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CreditW] ? {CreditW{1'b1}} : sum[CreditW-1:0];
   endfunction

endpackage

// File: rtl/change_dispenser_coin_selector.sv
// Greedy coin picker: the largest denomination not exceeding the amount owed
// whose tube still holds at least one coin.
module coin_selector
   import change_dispenser_pkg::*;
#(
   parameter int unsigned DENOM_A = DenomADefault,
   parameter int unsigned DENOM_B = DenomBDefault,
   parameter int unsigned DENOM_C = DenomCDefault
) (
   input  logic [CreditW-1:0] remaining,
   input  logic [3:0]         inv_a,
   input  logic [3:0]         inv_b,
   input  logic [3:0]         inv_c,
   output logic               found,
   output logic [1:0]         sel,
   output logic [CreditW-1:0] denom
);

   localparam logic [CreditW-1:0] DenA = CreditW'(DENOM_A);
   localparam logic [CreditW-1:0] DenB = CreditW'(DENOM_B);
   localparam logic [CreditW-1:0] DenC = CreditW'(DENOM_C);

   always_comb begin
      found = 1'b0;
      sel   = SelA;
      denom = '0;
      if (remaining >= DenA && inv_a != 4'd0) begin
         found = 1'b1;
         sel   = SelA;
         denom = DenA;
      end else if (remaining >= DenB && inv_b != 4'd0) begin
         found = 1'b1;
         sel   = SelB;
         denom = DenB;
      end else if (remaining >= DenC && inv_c != 4'd0) begin
         found = 1'b1;
         sel   = SelC;
         denom = DenC;
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Change payout engine: latches owed change, ejects coins greedily over a 4-phase
// hopper handshake and tracks tube inventory. CHANGE_TIMEOUT_EN adds an ack watchdog.
module change_dispenser
   import change_dispenser_pkg::*;
#(
   parameter int unsigned DENOM_A  = DenomADefault,
   parameter int unsigned DENOM_B  = DenomBDefault,
   parameter int unsigned DENOM_C  = DenomCDefault,
   parameter int unsigned INV_INIT = 8
`ifdef CHANGE_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 1000
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               change_returning,
   input  logic [CreditW-1:0] change_due,
   input  logic               refill,
   output logic               eject_req,
   output logic [1:0]         eject_sel,
   input  logic               eject_ack,
   output logic               busy,
   output logic [CreditW-1:0] remaining,
   output logic [3:0]         inv_a,
   output logic [3:0]         inv_b,
   output logic [3:0]         inv_c,
   output logic               dispense_done,
   output logic               short_flag,
   output logic               timeout_flag
);

   localparam logic [3:0] InvInit = 4'(INV_INIT);

   state_e             state_q, state_d;
   logic [1:0]         sel_q, sel_d;
   logic [CreditW-1:0] denom_q, denom_d;
   logic [CreditW-1:0] remaining_q, remaining_d, rem_base;
   logic [3:0]         inv_a_q, inv_b_q, inv_c_q;
   logic               pick_found;
   logic [1:0]         pick_sel;
   logic [CreditW-1:0] pick_denom;
   logic               ack_take, timeout, wd_expire;

   coin_selector #(
      .DENOM_A (DENOM_A),
      .DENOM_B (DENOM_B),
      .DENOM_C (DENOM_C)
   ) u_coin_selector (
      .remaining (remaining_q),
      .inv_a     (inv_a_q),
      .inv_b     (inv_b_q),
      .inv_c     (inv_c_q),
      .found     (pick_found),
      .sel       (pick_sel),
      .denom     (pick_denom)
   );

`ifdef CHANGE_TIMEOUT_EN
   localparam logic [9:0] TimeoutLast = 10'(TIMEOUT_CYCLES - 1);
   logic [9:0] wd_q, wd_d;

   assign wd_expire = (wd_q == TimeoutLast);

   // Watchdog only runs while a coin is in flight and restarts on every state change.
   always_comb begin
      wd_d = '0;
      if (state_d == state_q && (state_q == StEject || state_q == StRelease)) begin
         wd_d = wd_q + 10'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wd_q <= '0;
      else     wd_q <= wd_d;
   end
`else
   assign wd_expire = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      denom_d  = denom_q;
      ack_take = 1'b0;
      timeout  = 1'b0;
      unique case (state_q)
         StIdle: if (change_returning) state_d = StSelect;
         StSelect: begin
            if (remaining_q == '0) begin
               state_d = StDone;
            end else if (pick_found) begin
               sel_d   = pick_sel;
               denom_d = pick_denom;
               state_d = StEject;
            end else begin
               state_d = StShort;
            end
         end
         StEject: begin
            if (eject_ack) begin
               ack_take = 1'b1;
               state_d  = StRelease;
            end else if (wd_expire) begin
               timeout = 1'b1;
               state_d = StShort;
            end
         end
         StRelease: begin
            if (!eject_ack) begin
               state_d = StSelect;
            end else if (wd_expire) begin
               timeout = 1'b1;
               state_d = StShort;
            end
         end
         StDone:  state_d = StIdle;
         StShort: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // The selected coin never exceeds the debt, so the subtraction cannot wrap.
      rem_base = ack_take ? remaining_q - denom_q : remaining_q;
      remaining_d = change_returning ? sat_add(rem_base, change_due) : rem_base;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         sel_q       <= SelA;
         denom_q     <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         denom_q     <= denom_d;
         remaining_q <= remaining_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inv_a_q <= InvInit;
         inv_b_q <= InvInit;
         inv_c_q <= InvInit;
      end else if (state_q == StIdle && refill) begin
         inv_a_q <= InvInit;
         inv_b_q <= InvInit;
         inv_c_q <= InvInit;
      end else if (ack_take) begin
         unique case (sel_q)
            SelA:    inv_a_q <= inv_a_q - 4'd1;
            SelB:    inv_b_q <= inv_b_q - 4'd1;
            default: inv_c_q <= inv_c_q - 4'd1;
         endcase
      end
   end

   assign eject_req     = (state_q == StEject) && !timeout;
   assign eject_sel     = sel_q;
   assign busy          = (state_q != StIdle);
   assign remaining     = remaining_q;
   assign inv_a         = inv_a_q;
   assign inv_b         = inv_b_q;
   assign inv_c         = inv_c_q;
   assign dispense_done = (state_q == StDone);
   assign short_flag    = (state_q == StShort);
   assign timeout_flag  = timeout;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with an auto-acking hopper model.
// Define CHANGE_TIMEOUT_EN to also exercise the ack watchdog.
module tb_change_dispenser;

   logic       clk = 1'b0;
   logic       rst;
   logic       change_returning;
   logic [7:0] change_due;
   logic       refill;
   logic       eject_req;
   logic [1:0] eject_sel;
   logic       eject_ack;
   logic       busy;
   logic [7:0] remaining;
   logic [3:0] inv_a, inv_b, inv_c;
   logic       dispense_done, short_flag, timeout_flag;

   int total = 0;
   int bad   = 0;
   int done_cnt, short_cnt;
   logic [1:0] sel_log[$];
   logic [7:0] rem_log[$];
   bit   hopper_en;
   logic req_prev = 1'b0;

   always #5 clk = ~clk;

   change_dispenser #(
      .INV_INIT (8)
`ifdef CHANGE_TIMEOUT_EN
      , .TIMEOUT_CYCLES (16)
`endif
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .change_returning (change_returning),
      .change_due       (change_due),
      .refill           (refill),
      .eject_req        (eject_req),
      .eject_sel        (eject_sel),
      .eject_ack        (eject_ack),
      .busy             (busy),
      .remaining        (remaining),
      .inv_a            (inv_a),
      .inv_b            (inv_b),
      .inv_c            (inv_c),
      .dispense_done    (dispense_done),
      .short_flag       (short_flag),
      .timeout_flag     (timeout_flag)
   );

   // Hopper: acks one cycle after a request appears, drops ack once req falls.
   initial begin
      eject_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (hopper_en && eject_req && !eject_ack) begin
            eject_ack = 1'b1;
            sel_log.push_back(eject_sel);
         end else if (eject_ack && !eject_req) begin
            eject_ack = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (dispense_done) done_cnt++;
      if (short_flag) short_cnt++;
      if (eject_req && !req_prev) rem_log.push_back(remaining);
      req_prev = eject_req;
   end

   task automatic clear_logs();
      sel_log.delete();
      rem_log.delete();
      done_cnt  = 0;
      short_cnt = 0;
   endtask

   task automatic pulse_change(input logic [7:0] due);
      @(posedge clk); #1;
      change_returning = 1'b1;
      change_due       = due;
      @(posedge clk); #1;
      change_returning = 1'b0;
      change_due       = 8'd0;
   endtask

   task automatic pulse_refill();
      @(posedge clk); #1;
      refill = 1'b1;
      @(posedge clk); #1;
      refill = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (busy) begin
         bad++;
         $display("FAIL %s idle: busy=%0b after %0d cycles, required 0", name, busy, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; change_returning = 1'b0; change_due = 8'd0; refill = 1'b0;
      hopper_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (eject_req !== 1'b0) begin bad++; $display("FAIL reset eject_req: got %0b want 0", eject_req); end
      total++; if (eject_sel !== 2'd0) begin bad++; $display("FAIL reset eject_sel: got %0d want 0", eject_sel); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %0b want 0", busy); end
      total++; if (remaining !== 8'd0) begin bad++; $display("FAIL reset remaining: got %0d want 0", remaining); end
      total++; if ({dispense_done, short_flag, timeout_flag} !== 3'b000) begin
         bad++; $display("FAIL reset flags: got %b want 000", {dispense_done, short_flag, timeout_flag});
      end
      total++; if ({inv_a, inv_b, inv_c} !== {4'd8, 4'd8, 4'd8}) begin
         bad++; $display("FAIL reset inv: got %0d/%0d/%0d want 8/8/8", inv_a, inv_b, inv_c);
      end
   endtask

   task automatic test_greedy_8();
      logic [1:0] exp_sel [3] = '{2'd0, 2'd1, 2'd2};
      clear_logs();
      pulse_change(8'd8);
      wait_idle("greedy8");
      total++;
      if (sel_log.size() != 3) begin
         bad++; $display("FAIL greedy8 coin count: got %0d want 3", sel_log.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (sel_log[i] !== exp_sel[i]) begin
               bad++; $display("FAIL greedy8 sel[%0d]: got %0d want %0d", i, sel_log[i], exp_sel[i]);
            end
         end
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL greedy8 done pulses: got %0d want 1", done_cnt); end
      total++; if (short_cnt != 0) begin bad++; $display("FAIL greedy8 short pulses: got %0d want 0", short_cnt); end
      total++; if (remaining !== 8'd0) begin bad++; $display("FAIL greedy8 remaining: got %0d want 0", remaining); end
      total++; if ({inv_a, inv_b, inv_c} !== {4'd7, 4'd7, 4'd7}) begin
         bad++; $display("FAIL greedy8 inv: got %0d/%0d/%0d want 7/7/7", inv_a, inv_b, inv_c);
      end
   endtask

   task automatic test_latency_4();
      clear_logs();
      @(posedge clk); #1;
      change_returning = 1'b1;
      change_due       = 8'd4;
      @(negedge clk);
      total++; if (eject_req !== 1'b0) begin bad++; $display("FAIL latency N: eject_req=%0b want 0", eject_req); end
      @(posedge clk); #1;
      change_returning = 1'b0;
      change_due       = 8'd0;
      @(negedge clk);
      total++; if (eject_req !== 1'b0) begin bad++; $display("FAIL latency N+1: eject_req=%0b want 0", eject_req); end
      @(negedge clk);
      total++; if (eject_req !== 1'b1) begin bad++; $display("FAIL latency N+2: eject_req=%0b want 1", eject_req); end
      wait_idle("four");
      total++;
      if (sel_log.size() != 2 || rem_log.size() != 2) begin
         bad++; $display("FAIL four coin count: got %0d/%0d want 2/2", sel_log.size(), rem_log.size());
      end else begin
         total++; if (sel_log[0] !== 2'd1 || sel_log[1] !== 2'd1) begin
            bad++; $display("FAIL four sel: got %0d,%0d want 1,1", sel_log[0], sel_log[1]);
         end
         total++; if (rem_log[0] !== 8'd4 || rem_log[1] !== 8'd2) begin
            bad++; $display("FAIL four remaining trace: got %0d,%0d want 4,2", rem_log[0], rem_log[1]);
         end
      end
      total++; if (remaining !== 8'd0) begin bad++; $display("FAIL four remaining: got %0d want 0", remaining); end
      total++; if ({inv_a, inv_b, inv_c} !== {4'd7, 4'd5, 4'd7}) begin
         bad++; $display("FAIL four inv: got %0d/%0d/%0d want 7/5/7", inv_a, inv_b, inv_c);
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL four done pulses: got %0d want 1", done_cnt); end
   endtask

   task automatic test_short();
      pulse_refill();
      clear_logs();
      pulse_change(8'd70);
      wait_idle("short");
      total++;
      if (sel_log.size() != 24) begin
         bad++; $display("FAIL short coin count: got %0d want 24", sel_log.size());
      end else begin
         for (int i = 0; i < 24; i++) begin
            total++;
            if (sel_log[i] !== 2'(i / 8)) begin
               bad++; $display("FAIL short sel[%0d]: got %0d want %0d", i, sel_log[i], i / 8);
            end
         end
      end
      total++; if (short_cnt != 1) begin bad++; $display("FAIL short pulses: got %0d want 1", short_cnt); end
      total++; if (done_cnt != 0) begin bad++; $display("FAIL short done pulses: got %0d want 0", done_cnt); end
      total++; if (remaining !== 8'd6) begin bad++; $display("FAIL short remaining: got %0d want 6", remaining); end
      total++; if ({inv_a, inv_b, inv_c} !== 12'd0) begin
         bad++; $display("FAIL short inv: got %0d/%0d/%0d want 0/0/0", inv_a, inv_b, inv_c);
      end
      // Refill alone must not restart payout of the leftover debt.
      clear_logs();
      pulse_refill();
      repeat (4) @(negedge clk);
      total++; if (busy !== 1'b0 || remaining !== 8'd6) begin
         bad++; $display("FAIL refill idle: busy=%0b remaining=%0d want 0/6", busy, remaining);
      end
      total++; if ({inv_a, inv_b, inv_c} !== {4'd8, 4'd8, 4'd8}) begin
         bad++; $display("FAIL refill inv: got %0d/%0d/%0d want 8/8/8", inv_a, inv_b, inv_c);
      end
      pulse_change(8'd0);
      wait_idle("resume");
      total++; if (sel_log.size() != 2) begin
         bad++; $display("FAIL resume coin count: got %0d want 2", sel_log.size());
      end else begin
         total++; if (sel_log[0] !== 2'd0 || sel_log[1] !== 2'd2) begin
            bad++; $display("FAIL resume sel: got %0d,%0d want 0,2", sel_log[0], sel_log[1]);
         end
      end
      total++; if (remaining !== 8'd0 || done_cnt != 1) begin
         bad++; $display("FAIL resume end: remaining=%0d done=%0d want 0/1", remaining, done_cnt);
      end
   endtask

   task automatic test_zero();
      clear_logs();
      pulse_change(8'd0);
      wait_idle("zero");
      total++; if (done_cnt != 1 || sel_log.size() != 0) begin
         bad++; $display("FAIL zero: done=%0d coins=%0d want 1/0", done_cnt, sel_log.size());
      end
   endtask

   task automatic test_merge();
      int n = 0;
      pulse_refill();
      clear_logs();
      @(posedge clk); #1;
      change_returning = 1'b1;
      change_due       = 8'd5;
      @(posedge clk); #1;
      change_returning = 1'b0;
      change_due       = 8'd0;
      while (!eject_req && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      total++; if (eject_req !== 1'b1) begin bad++; $display("FAIL merge req: got %0b want 1", eject_req); end
      // Second request lands on the same edge as the first coin's ack.
      change_returning = 1'b1;
      change_due       = 8'd3;
      @(posedge clk); #1;
      change_returning = 1'b0;
      change_due       = 8'd0;
      wait_idle("merge");
      total++;
      if (rem_log.size() != 3 || sel_log.size() != 3) begin
         bad++; $display("FAIL merge coin count: got %0d/%0d want 3/3", rem_log.size(), sel_log.size());
      end else begin
         total++; if (rem_log[1] !== 8'd3 || rem_log[2] !== 8'd1) begin
            bad++; $display("FAIL merge remaining trace: got %0d,%0d want 3,1", rem_log[1], rem_log[2]);
         end
         total++; if (sel_log[0] !== 2'd0 || sel_log[1] !== 2'd1 || sel_log[2] !== 2'd2) begin
            bad++; $display("FAIL merge sel: got %0d,%0d,%0d want 0,1,2", sel_log[0], sel_log[1], sel_log[2]);
         end
      end
      total++; if (done_cnt != 1 || remaining !== 8'd0) begin
         bad++; $display("FAIL merge end: done=%0d remaining=%0d want 1/0", done_cnt, remaining);
      end
   endtask

   task automatic test_sat_reset();
      int n = 0;
      hopper_en = 1'b0;
      clear_logs();
      pulse_change(8'd200);
      while (!eject_req && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      pulse_change(8'd100);
      total++; if (remaining !== 8'd255) begin bad++; $display("FAIL saturate: got %0d want 255", remaining); end
      total++; if (eject_req !== 1'b1) begin bad++; $display("FAIL hold req: got %0b want 1", eject_req); end
      #2 rst = 1'b1;
      #1;
      total++; if (eject_req !== 1'b0) begin bad++; $display("FAIL async reset req: got %0b want 0", eject_req); end
      total++; if (remaining !== 8'd0 || busy !== 1'b0) begin
         bad++; $display("FAIL async reset state: remaining=%0d busy=%0b want 0/0", remaining, busy);
      end
      total++; if ({inv_a, inv_b, inv_c} !== {4'd8, 4'd8, 4'd8}) begin
         bad++; $display("FAIL async reset inv: got %0d/%0d/%0d want 8/8/8", inv_a, inv_b, inv_c);
      end
      @(negedge clk);
      rst = 1'b0;
      hopper_en = 1'b1;
   endtask

`ifdef CHANGE_TIMEOUT_EN
   task automatic test_timeout();
      int n = 0;
      hopper_en = 1'b0;
      clear_logs();
      pulse_change(8'd7);
      @(negedge clk);
      while (!timeout_flag && n < 100) begin
         @(negedge clk);
         n++;
      end
      total++; if (timeout_flag !== 1'b1) begin bad++; $display("FAIL timeout flag: got %0b want 1", timeout_flag); end
      total++; if (eject_req !== 1'b0) begin bad++; $display("FAIL timeout req: got %0b want 0", eject_req); end
      @(negedge clk);
      total++; if (short_flag !== 1'b1) begin bad++; $display("FAIL timeout short: got %0b want 1", short_flag); end
      wait_idle("timeout");
      total++; if (remaining !== 8'd7 || inv_a !== 4'd8) begin
         bad++; $display("FAIL timeout end: remaining=%0d inv_a=%0d want 7/8", remaining, inv_a);
      end
      hopper_en = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_greedy_8();
      test_latency_4();
      test_short();
      test_zero();
      test_merge();
      test_sat_reset();
`ifdef CHANGE_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
